// File: rtl/vn_cpu_top.sv
// Minimal 8-bit accumulator CPU. Instructions and data share one 64x8 memory
// reached over a 6-bit address bus and a bidirectional 8-bit data bus.
module vn_cpu_top (
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] adr_bus,
    output logic       rd_mem,
    output logic       wr_mem,
    inout  wire  [7:0] data_bus
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;

    state_t     state_q, state_d;
    logic [5:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] ac_q, ac_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_INIT;
            pc_q    <= 6'd0;
            ir_q    <= 8'd0;
            ac_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
        end
    end

    // Bus outputs depend only on registered state, IR and PC.
    always_comb begin
        state_d = S_INIT;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        adr_bus = 6'd0;
        rd_mem  = 1'b0;
        wr_mem  = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                adr_bus = pc_q;
                rd_mem  = 1'b1;
                ir_d    = data_bus;
                pc_d    = pc_q + 6'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                adr_bus = pc_q;
                case (ir_q[7:6])
                    OP_JMP: begin
                        pc_d    = ir_q[5:0];
                        state_d = S_FETCH;
                    end
                    OP_STA:  state_d = S_WRITE;
                    default: state_d = S_READ;
                endcase
            end
            S_READ: begin
                adr_bus = ir_q[5:0];
                rd_mem  = 1'b1;
                ac_d    = (ir_q[7:6] == OP_LDA) ? data_bus : ac_q + data_bus;
                state_d = S_FETCH;
            end
            S_WRITE: begin
                adr_bus = ir_q[5:0];
                wr_mem  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign data_bus = wr_mem ? ac_q : 8'hzz;

endmodule

// File: tb/tb_vn_cpu_top.sv
// Bench for vn_cpu_top: external memory, instruction-level reference model
// that expands each instruction into its expected bus cycles, and directed plus random runs.
module tb_vn_cpu_top;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] adr_bus;
    logic       rd_mem, wr_mem;
    wire  [7:0] data_bus;

    always #5 clk = ~clk;

    vn_cpu_top dut (
        .clk      (clk),
        .reset    (reset),
        .adr_bus  (adr_bus),
        .rd_mem   (rd_mem),
        .wr_mem   (wr_mem),
        .data_bus (data_bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- system memory ----------------
    logic [7:0] mem [64];
    logic [7:0] img [64];
    logic [7:0] probe = 8'h00;

    // When the core is not writing, the bench drives either the read data or a
    // changing probe byte; a core that drives out of turn corrupts what is seen.
    assign data_bus = !wr_mem ? (rd_mem ? mem[adr_bus] : probe) : 8'hzz;

    always @(posedge clk) probe = 8'($urandom);
    always @(negedge clk) if (wr_mem === 1'b1) mem[adr_bus] = data_bus;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [5:0] adr;
        logic [7:0] dat;
    } cyc_t;

    cyc_t       q[$];
    logic [7:0] mm [64];
    logic [5:0] mpc;
    logic [7:0] mac;
    bit         mvalid = 0;

    task automatic gen_instr();
        logic [7:0] ir;
        logic [5:0] a;
        ir = mm[mpc];
        a  = ir[5:0];
        q.push_back('{rd: 1'b1, wr: 1'b0, adr: mpc, dat: 8'h00});
        mpc = mpc + 6'd1;
        q.push_back('{rd: 1'b0, wr: 1'b0, adr: mpc, dat: 8'h00});
        case (ir[7:6])
            2'b00: begin q.push_back('{rd: 1'b1, wr: 1'b0, adr: a, dat: 8'h00}); mac = mm[a]; end
            2'b01: q.push_back('{rd: 1'b0, wr: 1'b1, adr: a, dat: mac});
            2'b10: mpc = a;
            default: begin q.push_back('{rd: 1'b1, wr: 1'b0, adr: a, dat: 8'h00}); mac = 8'(mac + mm[a]); end
        endcase
    endtask

    always @(posedge clk) begin
        cyc_t c;
        if (mvalid && q.size() > 0) begin
            c = q.pop_front();
            if (c.wr) mm[c.adr] = c.dat;
        end
        if (reset == 1'b0) begin
            q.delete();
            mpc = 6'd0;
            mac = 8'd0;
            q.push_back('{rd: 1'b0, wr: 1'b0, adr: 6'd0, dat: 8'h00});
            mvalid = 1;
        end else if (mvalid && q.size() == 0) begin
            gen_instr();
        end
    end

    // Compare process: every cycle, mid-cycle.
    always @(negedge clk) begin
        if (mvalid && q.size() > 0) begin
            chk("rd_and_wr", 32'(rd_mem & wr_mem), 32'd0);
            chk("rd_mem", 32'(rd_mem), 32'(q[0].rd));
            chk("wr_mem", 32'(wr_mem), 32'(q[0].wr));
            chk("adr_bus", 32'(adr_bus), 32'(q[0].adr));
            if (q[0].wr)      chk("wr_data", 32'(data_bus), 32'(q[0].dat));
            else if (!q[0].rd) chk("bus_released", 32'(data_bus), 32'(probe));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string nm, input logic rd, input logic wr, input logic [5:0] a);
        chk({nm, ".rd"}, 32'(rd_mem), 32'(rd));
        chk({nm, ".wr"}, 32'(wr_mem), 32'(wr));
        chk({nm, ".adr"}, 32'(adr_bus), 32'(a));
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 8'h00;
    endtask

    // Hold reset for three edges, load memory, release in the INIT cycle.
    task automatic boot();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 64; i++) begin mem[i] = img[i]; mm[i] = img[i]; end
        cyc(2);
        chk_bus("reset_idle", 1'b0, 1'b0, 6'd0);
        @(negedge clk) reset = 1'b1;
        chk_bus("init_cycle", 1'b0, 1'b0, 6'd0);
    endtask

    task automatic load_add_store(input logic [7:0] x, input logic [7:0] y);
        clear_img();
        img[0] = 8'h0A; img[1] = 8'hCB; img[2] = 8'h4C; img[3] = 8'h80;
        img[6'h0A] = x; img[6'h0B] = y;
    endtask

    initial begin
        bit seen;
        // Load/add/store loop
        load_add_store(8'h05, 8'h03);
        boot();
        cyc(1); chk_bus("first_fetch", 1'b1, 1'b0, 6'd0);
        cyc(7); chk("pre_write.wr", 32'(wr_mem), 32'd0);
        cyc(1); chk_bus("write9", 1'b0, 1'b1, 6'h0C);
        chk("write9.data", 32'(data_bus), 32'h08);
        cyc(1); chk("write_pulse_len", 32'(wr_mem), 32'd0);
        cyc(10); chk_bus("write20", 1'b0, 1'b1, 6'h0C);
        chk("write20.data", 32'(data_bus), 32'h08);
        cyc(2); chk("mem_0C", 32'(mem[6'h0C]), 32'h08);

        // ADD overflow
        load_add_store(8'hF0, 8'h20);
        boot();
        cyc(9); chk_bus("ovf_write", 1'b0, 1'b1, 6'h0C);
        chk("ovf_data", 32'(data_bus), 32'h10);
        cyc(2); chk("ovf_mem_0C", 32'(mem[6'h0C]), 32'h10);
        chk("ovf_mem_0A", 32'(mem[6'h0A]), 32'hF0);
        chk("ovf_mem_0B", 32'(mem[6'h0B]), 32'h20);

        // JMP and PC wrap
        clear_img();
        img[0] = 8'hBF; img[6'h3F] = 8'h0A;
        boot();
        cyc(1); chk_bus("jmp_fetch0", 1'b1, 1'b0, 6'h00);
        cyc(1); chk_bus("jmp_decode", 1'b0, 1'b0, 6'h01);
        cyc(1); chk_bus("jmp_fetch3F", 1'b1, 1'b0, 6'h3F);
        cyc(1); chk_bus("wrap_decode", 1'b0, 1'b0, 6'h00);
        cyc(1); chk_bus("lda_read", 1'b1, 1'b0, 6'h0A);
        cyc(1); chk_bus("wrap_fetch", 1'b1, 1'b0, 6'h00);

        // Reset in the middle of a WRITE cycle
        load_add_store(8'h05, 8'h03);
        boot();
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1);
            if (wr_mem === 1'b1) seen = 1;
        end
        chk("write_seen", 32'(seen), 32'd1);
        @(negedge clk) reset = 1'b0;
        cyc(1); chk_bus("mid_write_reset", 1'b0, 1'b0, 6'd0);
        chk("mid_write_released", 32'(data_bus), 32'(probe));
        chk("mid_write_mem", 32'(mem[6'h0C]), 32'h08);
        @(negedge clk) reset = 1'b1;
        cyc(1); chk_bus("restart_fetch", 1'b1, 1'b0, 6'd0);
        cyc(30);

        // Random programs with occasional resets, checked by the model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
            boot();
            for (int k = 0; k < 1500; k++) begin
                @(negedge clk) reset = ($urandom_range(0, 199) != 0);
            end
            @(negedge clk) reset = 1'b1;
            cyc(20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
